// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor: watches a one-hot RED->GREEN->YELLOW lamp drive for illegal, out-of-order and stuck colours
module lamp_sequence_monitor #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       light,
    input  logic             clear,
    output logic             locked,
    output logic             err_illegal,
    output logic             err_order,
    output logic             err_stuck,
    output logic [CNT_W-1:0] cycle_count
);
    localparam logic [1:0] UNSYNC = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] FAULT  = 2'd2;
    localparam logic [2:0] RED    = 3'b100;
    logic [1:0]       state_q, state_d;
    logic [2:0]       last_q, last_d;
    logic [3:0]       hold_q, hold_d;
    logic             locked_q, locked_d;
    logic             ill_q, ill_d;
    logic             ord_q, ord_d;
    logic             stk_q, stk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             legal;
    logic [2:0]       succ;
    logic [3:0]       hold_inc;
    logic [CNT_W-1:0] cnt_inc;
    assign legal    = (light == 3'b100) || (light == 3'b010) || (light == 3'b001);
    // rotate right: RED->GREEN->YELLOW->RED
    assign succ     = {last_q[0], last_q[2:1]};
    assign hold_inc = hold_q + 4'd1;
    assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        ill_d   = ill_q;
        ord_d   = ord_q;
        stk_d   = stk_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = UNSYNC;
            last_d  = RED;
            hold_d  = '0;
            ill_d   = 1'b0;
            ord_d   = 1'b0;
            stk_d   = 1'b0;
            cnt_d   = '0;
        end else if (state_q == UNSYNC) begin
            if (legal) begin
                state_d = SYNC;
                last_d  = light;
                hold_d  = 4'd1;
            end
        end else if (state_q == SYNC) begin
            if (!legal) begin
                ill_d   = 1'b1;
                state_d = FAULT;
            end else if (light == last_q) begin
                hold_d = hold_inc;
                if (hold_inc == 4'(MAX_HOLD)) begin
                    stk_d   = 1'b1;
                    state_d = FAULT;
                end
            end else if (light == succ) begin
                last_d = light;
                hold_d = 4'd1;
                cnt_d  = last_q[0] ? cnt_inc : cnt_q;
            end else begin
                ord_d   = 1'b1;
                state_d = FAULT;
            end
        end
        locked_d = (state_d == SYNC);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= UNSYNC;
            last_q   <= RED;
            hold_q   <= '0;
            locked_q <= 1'b0;
            ill_q    <= 1'b0;
            ord_q    <= 1'b0;
            stk_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            locked_q <= locked_d;
            ill_q    <= ill_d;
            ord_q    <= ord_d;
            stk_q    <= stk_d;
            cnt_q    <= cnt_d;
        end
    end
    assign locked      = locked_q;
    assign err_illegal = ill_q;
    assign err_order   = ord_q;
    assign err_stuck   = stk_q;
    assign cycle_count = cnt_q;
endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// tb_lamp_sequence_monitor: directed vectors against hand-computed expectations; second instance uses CNT_W = 2
module tb_lamp_sequence_monitor;
    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] light;
    logic       clear;
    logic       locked, err_illegal, err_order, err_stuck;
    logic [7:0] cycle_count;
    logic       locked2, ill2, ord2, stk2;
    logic [1:0] cnt2;
    int         n_vec = 0;
    int         n_err = 0;

    lamp_sequence_monitor dut (
        .clock(clock), .reset_n(reset_n), .light(light), .clear(clear),
        .locked(locked), .err_illegal(err_illegal), .err_order(err_order),
        .err_stuck(err_stuck), .cycle_count(cycle_count)
    );

    lamp_sequence_monitor #(.MAX_HOLD(4), .CNT_W(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .light(light), .clear(clear),
        .locked(locked2), .err_illegal(ill2), .err_order(ord2),
        .err_stuck(stk2), .cycle_count(cnt2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic il, input logic od,
                           input logic st, input logic [7:0] cn);
        chk({tag, ".locked"}, 32'(locked), 32'(lk));
        chk({tag, ".illegal"}, 32'(err_illegal), 32'(il));
        chk({tag, ".order"}, 32'(err_order), 32'(od));
        chk({tag, ".stuck"}, 32'(err_stuck), 32'(st));
        chk({tag, ".count"}, 32'(cycle_count), 32'(cn));
    endtask

    task automatic step(input logic [2:0] l);
        light = l;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        light   = 3'b000;
        #3;
        chk_all("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clock);
        #1;
        chk_all("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        reset_n = 1'b1;
        step(3'b000);
        chk("unsync_ignores_000", 32'(locked), 32'd0);
        step(3'b100);
        chk("lock_first_sample", 32'(locked), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(3'b010);
            step(3'b001);
            step(3'b100);
        end
        chk_all("three_cycles", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        chk("three_cycles.cnt2", 32'(cnt2), 32'd3);
        step(3'b100);
        step(3'b100);
        step(3'b010);
        chk_all("hold3_then_next", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        step(3'b010);
        step(3'b010);
        chk("hold3_no_stuck", 32'(err_stuck), 32'd0);
        step(3'b010);
        chk_all("hold4_stuck", 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
        step(3'b110);
        step(3'b100);
        chk_all("fault_holds", 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
        clear = 1'b1;
        step(3'b110);
        clear = 1'b0;
        chk_all("clear_from_fault", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(3'b001);
        chk_all("sync_on_yellow", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(3'b100);
        chk("yellow_red_count", 32'(cycle_count), 32'd1);
        step(3'b010);
        step(3'b100);
        chk_all("order_error", 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        step(3'b001);
        chk_all("order_sticky", 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        clear = 1'b1;
        step(3'b010);
        clear = 1'b0;
        chk_all("clear_discards_sample", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(3'b010);
        chk("sync_on_green", 32'(locked), 32'd1);
        step(3'b110);
        chk_all("illegal_110", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        clear = 1'b1;
        step(3'b000);
        clear = 1'b0;
        step(3'b001);
        step(3'b000);
        chk_all("illegal_000", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("reset_in_fault_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(3'b001);
        chk_all("resync_after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(3'b100);
        for (int i = 0; i < 5; i++) begin
            step(3'b010);
            step(3'b001);
            step(3'b100);
        end
        chk("sat.cnt8", 32'(cycle_count), 32'd6);
        chk("sat.cnt2", 32'(cnt2), 32'd3);
        chk("sat.locked2", 32'(locked2), 32'd1);
        clear = 1'b1;
        step(3'b110);
        clear = 1'b0;
        chk("clear110.locked2", 32'(locked2), 32'd0);
        chk("clear110.ill2", 32'(ill2), 32'd0);
        chk("clear110.ord2", 32'(ord2), 32'd0);
        chk("clear110.stk2", 32'(stk2), 32'd0);
        chk("clear110.cnt2", 32'(cnt2), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lamp_sequence_monitor.md
LAMP_SEQUENCE_MONITOR -- requirements
Module: lamp_sequence_monitor

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive samples one colour may be held before it counts as stuck; legal range 2..15.
REQ-002 Parameter: CNT_W, default 8, width of the completed-cycle counter.
REQ-003 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: light  in  3  observed lamp drive, one-hot; bit2 = RED, bit1 = GREEN, bit0 = YELLOW.
REQ-006 Port: clear  in  1  synchronous re-arm request, sampled each rising edge.
REQ-007 Port: locked  out  1  high while the monitor is in SYNC.
REQ-008 Port: err_illegal  out  1  sticky flag; a non-one-hot light value was sampled while in SYNC.
REQ-009 Port: err_order  out  1  sticky flag; a legal colour arrived out of RED->GREEN->YELLOW->RED order.
REQ-010 Port: err_stuck  out  1  sticky flag; one colour was held for MAX_HOLD consecutive samples.
REQ-011 Port: cycle_count  out  CNT_W  number of completed YELLOW->RED transitions since reset or clear.

Function
REQ-012 The monitor SHALL sample light on every rising edge and drive all outputs from registers, so every response is visible one edge after the sample that caused it.
REQ-013 The state machine SHALL have three states: UNSYNC, SYNC and FAULT.
REQ-014 UNSYNC: the monitor SHALL ignore non-one-hot values and SHALL enter SYNC on the first legal one-hot sample, recording that sample as last colour with hold count 1.
REQ-015 SYNC, same colour as last: hold count SHALL increment; when it reaches MAX_HOLD, err_stuck SHALL set and the state SHALL go to FAULT.
REQ-016 SYNC, expected successor (RED->GREEN, GREEN->YELLOW, YELLOW->RED): last SHALL update and hold count SHALL reset to 1.
REQ-017 SYNC, YELLOW->RED: cycle_count SHALL also increment, saturating at all-ones with no wrap.
REQ-018 SYNC, non-one-hot sample (including 3'b000): err_illegal SHALL set and the state SHALL go to FAULT.
REQ-019 SYNC, legal colour that is neither last nor its successor: err_order SHALL set and the state SHALL go to FAULT.
REQ-020 Only one error flag SHALL set per offending sample; the illegal check takes precedence over the order and stuck checks.
REQ-021 FAULT: the monitor SHALL ignore light, hold all flags and cycle_count, and keep locked low.
REQ-022 clear SHALL have priority over every other condition in every state: the next state SHALL be UNSYNC, all error flags and cycle_count SHALL go to 0, and the current light sample SHALL be discarded.
REQ-023 The first legal sample after entering UNSYNC SHALL never raise an error, whatever colour it is.

Reset
REQ-024 While reset_n is low, the monitor SHALL immediately, without waiting for a clock edge, force: state UNSYNC, locked 0, err_illegal 0, err_order 0, err_stuck 0, cycle_count 0, last colour RED, hold count 0.
REQ-025 When reset_n deasserts mid-sequence, the monitor SHALL resynchronise per REQ-014 with no error flag raised.
REQ-026 Asserting reset_n low while in FAULT SHALL clear the fault exactly as clear does.

Verification
REQ-027 Sequence: reset, then light = 100, 010, 001 repeated 3 times, then 100 -> locked = 1 from the edge after the first sample; cycle_count = 3; no error flags.
REQ-028 Synchronised on GREEN, then light = 100 -> err_order = 1 and locked = 0 one edge later; cycle_count unchanged; flags hold until clear.
REQ-029 Synchronised, then light = 110 -> err_illegal = 1 only; separately, light = 000 -> err_illegal = 1.
REQ-030 MAX_HOLD = 4, light held at 010 for 4 samples -> err_stuck = 1 after the 4th sample; holding for 3 samples and then sending 001 -> no error.
REQ-031 CNT_W = 2: run 5 full cycles -> cycle_count saturates at 3; then pulse clear together with light = 110 -> UNSYNC, all outputs 0, no err_illegal.
REQ-032 Pull reset_n low between clock edges while in FAULT -> all outputs 0 before the next edge; after release, first sample 001 -> locked with no error.
